bam_mul_seq: RTL and testbench



---
 rtl/bam_pkg.sv | 19 +
 rtl/bam_row_gen.sv | 22 ++
 rtl/bam_mul_seq.sv | 125 ++++++++++++
 tb/tb_bam_mul_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bam_pkg.sv
// Shared types and width helpers for the broken-array multiplier family.
package bam_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } bam_state_e;

    // h_cut must encode 0..n so that "all rows cut" is representable.
    function automatic int unsigned hcut_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned vcut_width(input int unsigned n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/bam_row_gen.sv
// Combinational partial-product row: bits with i+j < v_cut removed, shifted into place.
module bam_row_gen #(
    parameter int unsigned N  = 8,
    parameter int unsigned HW = 4,
    parameter int unsigned VW = 4
) (
    input  logic [N-1:0]   a,
    input  logic           b_bit,
    input  logic [HW-1:0]  j,
    input  logic [VW-1:0]  v_cut,
    output logic [2*N-1:0] row
);

    logic [N-1:0] mask;

    for (genvar i = 0; i < N; i++) begin : g_mask
        assign mask[i] = (32'(i) + 32'(j)) >= 32'(v_cut);
    end

    assign row = b_bit ? ({{N{1'b0}}, a & mask} << j) : '0;

endmodule

// File: rtl/bam_mul_seq.sv
// Sequential broken-array multiplier: one partial-product row per cycle, cuts sampled per bundle.
module bam_mul_seq
    import bam_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned HW = hcut_width(N),
    parameter int unsigned VW = vcut_width(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [HW-1:0]  h_cut,
    input  logic [VW-1:0]  v_cut,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] p,
    output logic           busy
);

    localparam logic [HW-1:0] LastRow = HW'(N - 1);

    bam_state_e     state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [VW-1:0]  v_q, v_d;
    logic [HW-1:0]  j_q, j_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] p_q, p_d;

    logic [N-1:0]   b_sh;
    logic [2*N-1:0] row;
    logic           accept;

    assign b_sh = b_q >> j_q;

    bam_row_gen #(
        .N  (N),
        .HW (HW),
        .VW (VW)
    ) u_row_gen (
        .a     (a_q),
        .b_bit (b_sh[0]),
        .j     (j_q),
        .v_cut (v_q),
        .row   (row)
    );

    // in_ready is held low during reset so no bundle is taken while state is unknown.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign p         = p_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        v_d     = v_q;
        j_d     = j_q;
        acc_d   = acc_q;
        p_d     = p_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d   = a;
                    b_d   = b;
                    v_d   = v_cut;
                    j_d   = h_cut;
                    acc_d = '0;
                    if (32'(h_cut) >= N) begin
                        state_d = DONE;
                        p_d     = '0;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = acc_q + row;
                j_d   = j_q + 1'b1;
                if (j_q == LastRow) begin
                    state_d = DONE;
                    p_d     = acc_q + row;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            v_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            v_q     <= v_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
        end
    end

    // Product must hold steady while the consumer stalls.
    a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(p)));

endmodule

// File: tb/tb_bam_mul_seq.sv
// Directed-vector bench for bam_mul_seq (N=8): product, latency, backpressure, mid-run reset.
module tb_bam_mul_seq;

    localparam int unsigned N  = 8;
    localparam int unsigned HW = 4;
    localparam int unsigned VW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic [HW-1:0] h_cut = '0;
    logic [VW-1:0] v_cut = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   p;
    logic          busy;

    int checks = 0;
    int errors = 0;

    bam_mul_seq #(
        .N  (N),
        .HW (HW),
        .VW (VW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .h_cut     (h_cut),
        .v_cut     (v_cut),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  h;
        logic [3:0]  v;
        logic [15:0] exp_p;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] th,
                        input logic [3:0] tv);
        @(negedge clk);
        a        = ta;
        b        = tb;
        h_cut    = th;
        v_cut    = tv;
        in_valid = 1'b1;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; latency 1 means valid right after that edge.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            errors++;
            checks++;
            $display("FAIL out_valid_timeout: got 0 expected 1");
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    vec_t vecs[10];
    int   lat;

    initial begin
        vecs[0] = '{8'd255, 8'd255,  4'd6, 4'd7,  16'd48896, 3};
        vecs[1] = '{8'd255, 8'd255,  4'd0, 4'd0,  16'd65025, 9};
        vecs[2] = '{8'd3,   8'h40,   4'd6, 4'd7,  16'd128,   3};
        vecs[3] = '{8'd1,   8'h80,   4'd6, 4'd7,  16'd128,   3};
        vecs[4] = '{8'd1,   8'h40,   4'd6, 4'd7,  16'd0,     3};
        vecs[5] = '{8'd200, 8'd100,  4'd8, 4'd0,  16'd0,     1};
        vecs[6] = '{8'd255, 8'd255,  4'd0, 4'd15, 16'd0,     9};
        vecs[7] = '{8'd255, 8'd255,  4'd0, 4'd14, 16'd16384, 9};
        vecs[8] = '{8'hAA,  8'h0F,   4'd2, 4'd0,  16'd2040,  7};
        vecs[9] = '{8'd13,  8'd11,   4'd15, 4'd0, 16'd0,     1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_p", 32'(p), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int k = 0; k < 10; k++) begin
            send(vecs[k].a, vecs[k].b, vecs[k].h, vecs[k].v);
            wait_out(lat);
            check($sformatf("vec%0d_p", k), 32'(p), 32'(vecs[k].exp_p));
            check($sformatf("vec%0d_latency", k), 32'(lat), 32'(vecs[k].exp_lat));
            release_out();
            check($sformatf("vec%0d_idle", k), 32'(busy), 32'd0);
        end

        // Backpressure: hold out_ready low in DONE
        send(8'd255, 8'd255, 4'd6, 4'd7);
        check("bp_busy_in_calc", 32'(busy), 32'd1);
        wait_out(lat);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_p", c), 32'(p), 32'd48896);
            check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
        end
        release_out();
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_p_retained", 32'(p), 32'd48896);

        // Reset in the middle of CALC
        send(8'd255, 8'd255, 4'd0, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_p", 32'(p), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        send(8'd10, 8'd20, 4'd0, 4'd0);
        wait_out(lat);
        check("after_rst_p", 32'(p), 32'd200);
        check("after_rst_latency", 32'(lat), 32'd9);
        release_out();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
